// File: rtl/bitwise_lane_pkg.sv
// bitwise_lane_pkg -- shared types for the byte-serial lane deserializer.
//   state_t  : positional FSM state (which lane the next byte fills, or FULL)
//   LANES    : number of combiner input lanes fed by the deserializer
//   lane_t   : one lane word at the default lane width
//   triple_t : one complete operand triple at the default lane width
package bitwise_lane_pkg;

  localparam int LANES      = 3;
  localparam int LANE_W_DEF = 8;

  typedef enum logic [1:0] {
    L0   = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    FULL = 2'd3
  } state_t;

  typedef logic [LANE_W_DEF-1:0] lane_t;

  typedef struct packed {
    lane_t lane2;
    lane_t lane1;
    lane_t lane0;
  } triple_t;

endpackage

// File: rtl/bitwise_lane_out_reg.sv
// bitwise_lane_out_reg -- holding register for one complete operand triple.
//   clk, rst     : clock, async active-low reset
//   load         : capture lanes_d and raise valid_q on the next edge
//   lanes_d      : incoming triple, lane i in lanes_d[i]
//   out_ready    : consumer takes the held triple
//   lanes_q      : held triple, unchanged except on load
//   valid_q      : triple held
//   deliver      : valid_q & out_ready (handshake completes this cycle)
module bitwise_lane_out_reg
  import bitwise_lane_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [LANES-1:0][W-1:0]   lanes_d,
  input  logic                      out_ready,
  output logic [LANES-1:0][W-1:0]   lanes_q,
  output logic                      valid_q,
  output logic                      deliver
);

  assign deliver = valid_q & out_ready;

  // Data only moves on load so downstream combiner inputs never glitch;
  // after a deliver the stale triple simply stays parked on the lanes.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      lanes_q[g] <= '0;
      else if (load) lanes_q[g] <= lanes_d[g];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         valid_q <= 1'b0;
    else if (load)    valid_q <= 1'b1;
    else if (deliver) valid_q <= 1'b0;
  end

endmodule

// File: rtl/bitwise_lane_deserializer.sv
// bitwise_lane_deserializer -- groups a byte stream into operand triples.
//   clk, rst            : clock, async active-low reset
//   __in0               : serial byte data
//   __in_sof            : start-of-triple marker (resyncs a partial triple)
//   __in_valid/__in_ready : input handshake
//   __out0..__out2      : registered triple, lane 0..2
//   __out_valid/__out_ready : output handshake
//   __count             : delivered triples, wraps modulo 2^CNT_W
// Optional build macro BITWISE_LANE_DESER_PARITY_EN adds __in_par (even
// parity over __in0) and __par_err (sticky per-triple mismatch flag).
module bitwise_lane_deserializer
  import bitwise_lane_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     __in0,
  input  logic             __in_sof,
  input  logic             __in_valid,
  output logic             __in_ready,
  output logic [W-1:0]     __out0,
  output logic [W-1:0]     __out1,
  output logic [W-1:0]     __out2,
  output logic             __out_valid,
  input  logic             __out_ready,
  output logic [CNT_W-1:0] __count
`ifdef BITWISE_LANE_DESER_PARITY_EN
  ,
  input  logic             __in_par,
  output logic             __par_err
`endif
);

  state_t                  state;
  logic [W-1:0]            lane0_q, lane1_q;
  logic                    accept, deliver, load;
  logic [LANES-1:0][W-1:0] lanes_d, lanes_q;

  // In FULL the input side only moves when the consumer drains the triple
  // in the same cycle, so the pass-through avoids a bubble.
  assign __in_ready = (state != FULL) | __out_ready;
  assign accept     = __in_valid & __in_ready;
  // A marked byte in L2 resyncs instead of completing the triple.
  assign load       = (state == L2) & accept & ~__in_sof;

  always_comb begin
    lanes_d    = '0;
    lanes_d[0] = lane0_q;
    lanes_d[1] = lane1_q;
    lanes_d[2] = __in0;
  end

  bitwise_lane_out_reg #(.W(W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .lanes_d   (lanes_d),
    .out_ready (__out_ready),
    .lanes_q   (lanes_q),
    .valid_q   (__out_valid),
    .deliver   (deliver)
  );

  assign __out0 = lanes_q[0];
  assign __out1 = lanes_q[1];
  assign __out2 = lanes_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= L0;
      lane0_q <= '0;
      lane1_q <= '0;
    end else begin
      unique case (state)
        L0: if (accept) begin
          lane0_q <= __in0;
          state   <= L1;
        end
        L1: if (accept) begin
          if (__in_sof) begin
            lane0_q <= __in0;
            state   <= L1;
          end else begin
            lane1_q <= __in0;
            state   <= L2;
          end
        end
        L2: if (accept) begin
          if (__in_sof) begin
            lane0_q <= __in0;
            state   <= L1;
          end else begin
            state   <= FULL;
          end
        end
        FULL: if (deliver) begin
          // A byte accepted alongside the deliver always opens the next
          // triple, regardless of its sof marker.
          if (accept) begin
            lane0_q <= __in0;
            state   <= L1;
          end else begin
            state   <= L0;
          end
        end
        default: state <= L0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         __count <= '0;
    else if (deliver) __count <= __count + 1'b1;
  end

`ifdef BITWISE_LANE_DESER_PARITY_EN
  logic byte_perr, perr_acc;

  assign byte_perr = ^{__in0, __in_par};

  // perr_acc covers the bytes of the partial triple; it restarts on any
  // byte that lands in lane 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_acc  <= 1'b0;
      __par_err <= 1'b0;
    end else begin
      if (accept) begin
        if (state == L0 || state == FULL || __in_sof) perr_acc <= byte_perr;
        else                                          perr_acc <= perr_acc | byte_perr;
      end
      if (load)         __par_err <= perr_acc | byte_perr;
      else if (deliver) __par_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_lane_deserializer.sv
module tb_bitwise_lane_deserializer;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk, rst;
  logic [W-1:0]     in0;
  logic             in_sof, in_valid, in_ready;
  logic [W-1:0]     out0, out1, out2;
  logic             out_valid, out_ready;
  logic [CNT_W-1:0] count;
  logic             in_par, par_err;

  bitwise_lane_deserializer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .__in0       (in0),
    .__in_sof    (in_sof),
    .__in_valid  (in_valid),
    .__in_ready  (in_ready),
    .__out0      (out0),
    .__out1      (out1),
    .__out2      (out2),
    .__out_valid (out_valid),
    .__out_ready (out_ready),
    .__count     (count)
`ifdef BITWISE_LANE_DESER_PARITY_EN
    ,
    .__in_par    (in_par),
    .__par_err   (par_err)
`endif
  );

`ifndef BITWISE_LANE_DESER_PARITY_EN
  assign par_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] b0, b1, b2;
    logic         pe;
  } trip_t;

  trip_t            sb[$];
  int               checks = 0;
  int               errors = 0;
  int               m_state;          // 0..2 = expecting lane, 3 = FULL
  logic [W-1:0]     m_l0, m_l1;
  logic             m_pe;
  logic [CNT_W-1:0] m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_l0 = '0; m_l1 = '0; m_pe = 1'b0; m_count = '0;
    sb.delete();
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the
  // scoreboard, advance the model, then check registered state after the edge.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit s, input bit r, input bit bad);
    bit    acc, del, pe;
    trip_t t;
    in_valid = v; in0 = d; in_sof = s; out_ready = r; in_par = (^d) ^ bad;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (m_state != 3) || r});
    if (m_state == 3) begin
      t = sb[0];
      chk("out0", {24'd0, out0}, {24'd0, t.b0});
      chk("out1", {24'd0, out1}, {24'd0, t.b1});
      chk("out2", {24'd0, out2}, {24'd0, t.b2});
`ifdef BITWISE_LANE_DESER_PARITY_EN
      chk("par_err", {31'd0, par_err}, {31'd0, t.pe});
`endif
    end
    del = (m_state == 3) && r;
    acc = v && ((m_state != 3) || r);
    pe  = bad;
    if (del) begin
      void'(sb.pop_front());
      m_count++;
      if (!acc) m_state = 0;
    end
    if (acc) begin
      case (m_state)
        0, 3: begin m_l0 = d; m_pe = pe; m_state = 1; end
        1: if (s) begin m_l0 = d; m_pe = pe; end
           else   begin m_l1 = d; m_pe = m_pe | pe; m_state = 2; end
        default:
           if (s) begin m_l0 = d; m_pe = pe; m_state = 1; end
           else begin
             t.b0 = m_l0; t.b1 = m_l1; t.b2 = d; t.pe = m_pe | pe;
             sb.push_back(t);
             m_state = 3;
           end
      endcase
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_state == 3});
    chk("count", {28'd0, count}, {28'd0, m_count});
  endtask

  task automatic mid_reset();
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out0", {24'd0, out0}, 32'd0);
    chk("rst_out1", {24'd0, out1}, 32'd0);
    chk("rst_out2", {24'd0, out2}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [CNT_W-1:0] c0;
    rst = 1'b0; in0 = '0; in_sof = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_par = 1'b0;
    model_reset();
    #2;
    chk("por_out_valid", {31'd0, out_valid}, 32'd0);
    chk("por_out0", {24'd0, out0}, 32'd0);
    chk("por_count", {28'd0, count}, 32'd0);
    chk("por_in_ready", {31'd0, in_ready}, 32'd1);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Basic triple, then deliver.
    cyc(1, 8'h0F, 0, 1, 0);
    cyc(1, 8'hF0, 0, 1, 0);
    cyc(1, 8'hAA, 0, 1, 0);
    chk("t1_out0", {24'd0, out0}, 32'h0F);
    chk("t1_out2", {24'd0, out2}, 32'hAA);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t1_count", {28'd0, count}, 32'd1);

    // Back-to-back six bytes.
    for (int i = 0; i < 6; i++) cyc(1, 8'(8'h10 + i), 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);
    chk("t2_count", {28'd0, count}, 32'd3);

    // Stall with a triple held, then deliver+accept in the same cycle.
    cyc(1, 8'hA1, 0, 1, 0);
    cyc(1, 8'hA2, 0, 1, 0);
    cyc(1, 8'hA3, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'h99, 0, 0, 0);
    cyc(1, 8'h55, 0, 1, 0);
    cyc(1, 8'h66, 0, 1, 0);
    cyc(1, 8'h77, 0, 1, 0);
    chk("t3_out0", {24'd0, out0}, 32'h55);
    cyc(0, 8'h00, 0, 1, 0);

    // Resync on sof mid-triple.
    cyc(1, 8'h11, 0, 1, 0);
    cyc(1, 8'h22, 0, 1, 0);
    cyc(1, 8'h33, 1, 1, 0);
    cyc(1, 8'h44, 0, 1, 0);
    cyc(1, 8'h55, 0, 1, 0);
    chk("t4_out0", {24'd0, out0}, 32'h33);
    cyc(0, 8'h00, 0, 1, 0);
    // sof in L0 changes nothing.
    cyc(1, 8'hC0, 1, 1, 0);
    cyc(1, 8'hC1, 0, 1, 0);
    cyc(1, 8'hC2, 0, 1, 0);
    cyc(0, 8'h00, 0, 1, 0);

    // Counter wrap: 2^CNT_W more triples returns to the same count.
    c0 = count;
    for (int t = 0; t < (1 << CNT_W); t++) begin
      for (int b = 0; b < 3; b++) cyc(1, 8'($urandom_range(0, 255)), 0, 1, 0);
    end
    cyc(0, 8'h00, 0, 1, 0);
    chk("wrap_count", {28'd0, count}, {28'd0, c0});
    // From a fresh reset, 16 triples wrap to zero.
    mid_reset();
    for (int t = 0; t < (1 << CNT_W); t++) begin
      for (int b = 0; b < 3; b++) cyc(1, 8'($urandom_range(0, 255)), 0, 1, 0);
    end
    cyc(0, 8'h00, 0, 1, 0);
    chk("wrap_zero", {28'd0, count}, 32'd0);

    // Reset mid-triple; next triple aligns from L0.
    cyc(1, 8'hDE, 0, 1, 0);
    mid_reset();
    cyc(1, 8'h01, 0, 1, 0);
    cyc(1, 8'h02, 0, 1, 0);
    cyc(1, 8'h03, 0, 1, 0);
    chk("rs_out0", {24'd0, out0}, 32'h01);
    cyc(0, 8'h00, 0, 1, 0);

    // Parity: bad byte 2 flags that triple only.
    cyc(1, 8'h5A, 0, 1, 0);
    cyc(1, 8'h3C, 0, 1, 1);
    cyc(1, 8'h0F, 0, 0, 0);
`ifdef BITWISE_LANE_DESER_PARITY_EN
    chk("par_bad", {31'd0, par_err}, 32'd1);
`endif
    cyc(0, 8'h00, 0, 1, 0);
    cyc(1, 8'h81, 0, 1, 0);
    cyc(1, 8'h42, 0, 1, 0);
    cyc(1, 8'h24, 0, 0, 0);
`ifdef BITWISE_LANE_DESER_PARITY_EN
    chk("par_clean", {31'd0, par_err}, 32'd0);
`endif
    cyc(0, 8'h00, 0, 1, 0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
